// File: rtl/ro_pkg.sv
// Shared types and helpers for the cochlea readout scheduler.
package ro_pkg;

  // Default channel count; also the width of the gray slot counter.
  localparam int unsigned RO_NCH_DEFAULT = 4;

  // Widest gray code the helper functions handle.
  localparam int unsigned RO_MAXW = 32;

  // One slot's worth of readout data for a single channel.
  typedef struct packed {
    logic eve;
    logic pol;
    logic ovf;
  } ro_rec_t;

  // Next code of a w-bit binary-reflected gray counter; wraps to 0 after the last code.
  function automatic logic [RO_MAXW-1:0] gray_next(input logic [RO_MAXW-1:0] g,
                                                   input int unsigned      w);
    logic [RO_MAXW-1:0] b;
    logic [RO_MAXW-1:0] mask;
    b = '0;
    b[RO_MAXW-1] = g[RO_MAXW-1];
    for (int unsigned j = 0; j < RO_MAXW - 1; j++) begin
      b[RO_MAXW-2-j] = b[RO_MAXW-1-j] ^ g[RO_MAXW-2-j];
    end
    b = b + 32'd1;
    mask = (w >= RO_MAXW) ? '1 : ((32'd1 << w) - 32'd1);
    b = b & mask;
    return b ^ (b >> 1);
  endfunction

  // Index of the single bit that differs between a gray code and its successor.
  function automatic int unsigned toggle_index(input logic [RO_MAXW-1:0] g,
                                               input logic [RO_MAXW-1:0] n);
    logic [RO_MAXW-1:0] d;
    int unsigned        idx;
    d   = g ^ n;
    idx = 0;
    for (int unsigned j = 0; j < RO_MAXW; j++) begin
      if (d[j]) idx = j;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ro_block_n_gray_slot_gen.sv
// Enabled gray-code slot counter; sel names the bit that toggles on the next advance.
module gray_slot_gen
  import ro_pkg::*;
#(
  parameter int unsigned NCH = RO_NCH_DEFAULT,
  parameter int unsigned CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           en,
  output logic [NCH-1:0] gc,
  output logic [CW-1:0]  sel
);

  logic [NCH-1:0] gc_q;
  logic [NCH-1:0] gc_d;
  logic [NCH-1:0] gc_nxt;

  // Successor code, toggling bit index and hold-while-disabled next state.
  always_comb begin
    gc_nxt = NCH'(gray_next(RO_MAXW'(gc_q), NCH));
    sel    = CW'(toggle_index(RO_MAXW'(gc_q), RO_MAXW'(gc_nxt)));
    gc_d   = en ? gc_nxt : gc_q;
    gc     = gc_q;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) gc_q <= '0;
    else       gc_q <= gc_d;
  end

endmodule

// File: rtl/ro_block_n.sv
// Readout scheduler: captures per-channel event strobes and drains them onto
// one shared readout pair in gray-code slot order.
module ro_block_n
  import ro_pkg::*;
#(
  parameter int unsigned NCH    = RO_NCH_DEFAULT,
  parameter int unsigned CW     = $clog2(NCH),
  parameter int unsigned STICKY = 1
) (
  input  logic           clk_master,
  input  logic           rstb,
  input  logic           en,
  input  logic [NCH-1:0] in_eve,
  input  logic [NCH-1:0] in_pol_eve,
  output logic           out_mux_eve,
  output logic           out_mux_pol_eve,
  output logic           out_ovf,
  output logic [CW-1:0]  out_ch,
  output logic           out_valid
);

  logic [NCH-1:0] slot_gc;
  logic [CW-1:0]  sel;
  logic           unused_gc;

  // Per-channel capture state.
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] pol_q,  pol_d;
  logic [NCH-1:0] ovf_q,  ovf_d;

  // Output registers.
  ro_rec_t        rec_q, rec_d;
  logic [CW-1:0]  ch_q,  ch_d;
  logic           valid_q, valid_d;

  gray_slot_gen #(
    .NCH (NCH),
    .CW  (CW)
  ) u_slot (
    .clk  (clk_master),
    .rstb (rstb),
    .en   (en),
    .gc   (slot_gc),
    .sel  (sel)
  );

  // The slot code itself is only needed to derive sel.
  always_comb begin
    unused_gc = ^slot_gc;
  end

  // Capture: a read clears the channel, but an event arriving on the read
  // cycle re-arms it so that event surfaces at the channel's next slot.
  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    ovf_d  = ovf_q;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (en && (sel == CW'(k))) begin
        ovf_d[k] = 1'b0;
        if (in_eve[k]) begin
          pend_d[k] = 1'b1;
          pol_d[k]  = in_pol_eve[k];
        end else begin
          pend_d[k] = 1'b0;
        end
      end else if (in_eve[k]) begin
        pend_d[k] = 1'b1;
        pol_d[k]  = in_pol_eve[k];
        ovf_d[k]  = ovf_q[k] | pend_q[k];
      end
    end
    if (STICKY == 0) begin
      pend_d = '0;
      pol_d  = '0;
      ovf_d  = '0;
    end
  end

  // Slot read: load the selected channel on enabled cycles, hold otherwise.
  always_comb begin
    rec_d   = rec_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    if (en) begin
      valid_d = 1'b1;
      ch_d    = sel;
      if (STICKY != 0) begin
        rec_d.eve = pend_q[sel];
        rec_d.pol = pol_q[sel];
        rec_d.ovf = ovf_q[sel];
      end else begin
        rec_d.eve = in_eve[sel];
        rec_d.pol = in_pol_eve[sel];
        rec_d.ovf = 1'b0;
      end
    end
  end

  // All state registers; reset discards pending events and clears outputs.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      pend_q  <= '0;
      pol_q   <= '0;
      ovf_q   <= '0;
      rec_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      ovf_q   <= ovf_d;
      rec_q   <= rec_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  // Drive ports from the output registers.
  always_comb begin
    out_mux_eve     = rec_q.eve;
    out_mux_pol_eve = rec_q.pol;
    out_ovf         = rec_q.ovf;
    out_ch          = ch_q;
    out_valid       = valid_q;
  end

endmodule

// File: tb/tb_ro_block_n.sv
// Directed bench for ro_block_n (NCH=4): a STICKY=1 and a STICKY=0 instance share stimulus.
module tb_ro_block_n;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;

  logic           clk_master = 1'b0;
  logic           rstb;
  logic           en;
  logic [NCH-1:0] in_eve;
  logic [NCH-1:0] in_pol_eve;

  logic           eve, pol, ovf, valid;
  logic [CW-1:0]  ch;
  logic           s0_eve, s0_pol, s0_ovf, s0_valid;
  logic [CW-1:0]  s0_ch;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned pos     = 0;
  int unsigned slot_tbl [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 3};

  ro_block_n #(.NCH(NCH), .CW(CW), .STICKY(1)) dut (
    .clk_master      (clk_master),
    .rstb            (rstb),
    .en              (en),
    .in_eve          (in_eve),
    .in_pol_eve      (in_pol_eve),
    .out_mux_eve     (eve),
    .out_mux_pol_eve (pol),
    .out_ovf         (ovf),
    .out_ch          (ch),
    .out_valid       (valid)
  );

  ro_block_n #(.NCH(NCH), .CW(CW), .STICKY(0)) dut_s0 (
    .clk_master      (clk_master),
    .rstb            (rstb),
    .en              (en),
    .in_eve          (in_eve),
    .in_pol_eve      (in_pol_eve),
    .out_mux_eve     (s0_eve),
    .out_mux_pol_eve (s0_pol),
    .out_ovf         (s0_ovf),
    .out_ch          (s0_ch),
    .out_valid       (s0_valid)
  );

  always #5 clk_master = ~clk_master;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; checks slot order, valid and reset behaviour.
  task automatic cyc(input logic [NCH-1:0] ev, input logic [NCH-1:0] pl, input logic e);
    logic r;
    in_eve     = ev;
    in_pol_eve = pl;
    en         = e;
    r          = rstb;
    @(posedge clk_master);
    #1;
    in_eve     = '0;
    in_pol_eve = '0;
    en         = 1'b1;
    if (!r) begin
      check("reset_outs",    32'({eve, pol, ovf, ch, valid}), 32'd0);
      check("reset_outs_s0", 32'({s0_eve, s0_pol, s0_ovf, s0_ch, s0_valid}), 32'd0);
      pos = 0;
    end else if (e) begin
      check($sformatf("ch@%0d", pos),    32'(ch),    slot_tbl[pos]);
      check($sformatf("ch_s0@%0d", pos), 32'(s0_ch), slot_tbl[pos]);
      check("valid",    32'(valid),    32'd1);
      check("valid_s0", 32'(s0_valid), 32'd1);
      check("ovf_s0",   32'(s0_ovf),   32'd0);
      pos = (pos + 1) % 16;
    end else begin
      check("valid_off",    32'(valid),    32'd0);
      check("valid_off_s0", 32'(s0_valid), 32'd0);
    end
  endtask

  task automatic slot(input string tag, input logic e, input logic p, input logic o);
    check({tag, "_eve"}, 32'(eve), 32'(e));
    check({tag, "_pol"}, 32'(pol), 32'(p));
    check({tag, "_ovf"}, 32'(ovf), 32'(o));
  endtask

  // Enabled idle cycles over channels with nothing pending.
  task automatic adv(input int unsigned n, input logic all0);
    for (int unsigned i = 0; i < n; i++) begin
      cyc('0, '0, 1'b1);
      check("idle_eve", 32'(eve), 32'd0);
      check("idle_ovf", 32'(ovf), 32'd0);
      if (all0) check("idle_pol", 32'(pol), 32'd0);
    end
  endtask

  initial begin
    rstb = 1'b0; en = 1'b1; in_eve = '0; in_pol_eve = '0;

    // Reset, then first edge after release with en low, then two full slot periods.
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    rstb = 1'b1;
    cyc('0, '0, 1'b0);
    check("first_ch", 32'(ch), 32'd0);
    check("first_eve", 32'(eve), 32'd0);
    adv(32, 1'b1);

    // Single event on ch2 captured at pos0, reported at pos3, gone at pos11.
    cyc(4'b0100, 4'b0100, 1'b1);
    check("s0_other_ch", 32'(s0_eve), 32'd0);
    adv(2, 1'b1);
    cyc('0, '0, 1'b1);
    slot("single", 1'b1, 1'b1, 1'b0);
    adv(7, 1'b0);
    cyc('0, '0, 1'b1);
    check("single_after_eve", 32'(eve), 32'd0);

    // Two ch1 events (pol 1 then 0) before its slot at pos1.
    adv(2, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b1);
    check("ovf_pre0_eve", 32'(eve), 32'd0);
    cyc(4'b0010, 4'b0000, 1'b1);
    check("ovf_pre1_eve", 32'(eve), 32'd0);
    cyc('0, '0, 1'b1);
    check("ovf_pre2_eve", 32'(eve), 32'd0);
    cyc('0, '0, 1'b1);
    slot("ovf", 1'b1, 1'b0, 1'b1);
    check("s0_no_hold", 32'(s0_eve), 32'd0);
    adv(3, 1'b0);
    cyc('0, '0, 1'b1);
    slot("ovf_after", 1'b0, 1'b0, 1'b0);

    // ch0 pending, new ch0 event on its read cycle (pos8), re-reported at pos10.
    adv(1, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b1);
    check("rearm_pre_eve", 32'(eve), 32'd0);
    cyc(4'b0001, 4'b0000, 1'b1);
    slot("rearm_now", 1'b1, 1'b1, 1'b0);
    check("s0_direct_eve", 32'(s0_eve), 32'd1);
    check("s0_direct_pol", 32'(s0_pol), 32'd0);
    adv(1, 1'b0);
    cyc('0, '0, 1'b1);
    slot("rearm_next", 1'b1, 1'b0, 1'b0);

    // en low for 5 cycles with a ch3 event; outputs hold, sequence resumes at pos11.
    for (int unsigned i = 0; i < 5; i++) begin
      cyc((i == 1) ? 4'b1000 : 4'b0000, (i == 1) ? 4'b1000 : 4'b0000, 1'b0);
      check("hold_ch", 32'(ch), 32'd0);
      check("hold_eve", 32'(eve), 32'd1);
    end
    cyc('0, '0, 1'b1);
    check("resume_eve", 32'(eve), 32'd0);
    adv(3, 1'b0);
    cyc('0, '0, 1'b1);
    slot("en_ch3", 1'b1, 1'b1, 1'b0);

    // Events on all channels, then a one-cycle reset; everything reads back 0.
    cyc(4'b1111, 4'b1111, 1'b1);
    check("s0_all_eve", 32'(s0_eve), 32'd1);
    check("s0_all_pol", 32'(s0_pol), 32'd1);
    rstb = 1'b0;
    cyc(4'b1111, 4'b1111, 1'b1);
    rstb = 1'b1;
    adv(16, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_block_n.md
# ro_block_n

Parametrised readout scheduler for the cochlea core array. It captures event and polarity strobes from `NCH` channels and time-multiplexes them onto one shared readout pair using a built-in gray-code slot generator. Channel k is granted a slot at the rate of gray bit k, so fast cores are drained more often than slow ones. It replaces the per-core, edge-enabled tristate readout with one clocked block that holds events between slots and flags lost events; its outputs feed the existing pad tristate buffers.

## Interface
- `NCH`, 4: number of channels, ≥2; also the gray counter width.
- `CW`, `$clog2(NCH)`: width of the channel index.
- `STICKY`, 1: 1 = pending events accumulate until read; 0 = slot samples the input of that cycle only.
- `clk_master`  in  1  master clock; all logic on the rising edge.
- `rstb`  in  1  reset, synchronous, active-low.
- `en`  in  1  slot advance enable; capture continues while low.
- `in_eve`  in  NCH  per-channel event strobe; one cycle high = one event.
- `in_pol_eve`  in  NCH  polarity, qualified by `in_eve` of the same channel.
- `out_mux_eve`  out  1  event bit of the slot channel.
- `out_mux_pol_eve`  out  1  polarity of the slot channel.
- `out_ovf`  out  1  more than one event since the last read (STICKY=1 only).
- `out_ch`  out  CW  index of the slot channel.
- `out_valid`  out  1  slot outputs are valid; drives the pad tristate enable.

## Operation
- **Slot counter `gc`:** NCH-bit binary-reflected gray counter, reset 0.
  - Advances by one code per cycle while `en`=1.
  - Wraps from `1<<(NCH-1)` to 0.
- **Slot select `sel`:** index of the single bit that differs between `gc` and its next code.
  - With the counter index i in 0..2^NCH−2: `sel` = trailing-zero count of (i+1).
  - At the wrap: `sel` = NCH−1.
  - Read rates: channel k<NCH−1 is read every 2^(k+1) cycles. Channel NCH−1 is read twice per 2^NCH period.
- **Per-channel state:** `pend`, `pol` and `ovf` registers, all reset 0.
- **Capture, STICKY=1, on `in_eve[k]`=1:**
  - `pend[k]` ← 1.
  - `pol[k]` ← `in_pol_eve[k]`; the latest polarity wins.
  - `ovf[k]` ← 1 if `pend[k]` was already set and not being read this cycle.
- **Read of channel `sel`, when `en`=1:**
  - Output registers load `pend`, `pol` and `ovf` of channel `sel`, plus `sel` itself.
  - `out_valid` ← 1.
  - `pend[sel]` and `ovf[sel]` clear, unless `in_eve[sel]`=1 in the same cycle.
  - If `in_eve[sel]`=1 in the same cycle: `pend[sel]` ← 1 and `ovf[sel]` ← 0. The new event is not lost and is reported at that channel's next slot.
- **STICKY=0:**
  - Outputs load `in_eve[sel]` and `in_pol_eve[sel]` directly.
  - Per-channel registers unused; `out_ovf`=0.
- **`en`=0:**
  - `gc` holds.
  - `out_valid` ← 0; the other outputs hold their last value.
  - Capture continues and `ovf` accumulates normally.
- **Reset mid-operation:** `rstb`=0 at any edge clears `gc`, all pending state and all outputs. Events in that cycle are discarded.

## Timing
- Output latency: 1 cycle. Outputs registered at edge t+1 reflect `sel(gc at t)` and state as of t.
  - Same-cycle capture is excluded, except the re-arm rule above.
- `out_valid` is low at the first edge after reset release if `en`=0 then. With `en`=1 it is high from the first edge after reset release.
- All outputs are 0 during reset and at the first edge after release until the first read.
- Exactly one channel is read per enabled cycle; there are no idle slots.

## Structure
- **Package `ro_pkg`:**
  - Function `gray_next`.
  - Function `toggle_index`, returning the differing-bit index for a (gray, next) pair.
  - Constant for the default NCH.
- **Sub-module `gray_slot_gen`:** synchronous-reset, enabled gray counter. Outputs `gc` and `sel`.
- Top level holds the per-channel capture array and the output registers. Tristate buffers stay outside the block.

## Test plan
- **Slot sequence** (NCH=4, STICKY=1, `en`=1, no events): `out_ch` over 16 cycles = 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3. `out_mux_eve`=0 throughout. Sequence repeats.
- **Single event:** one-cycle `in_eve[2]`=1 with `in_pol_eve[2]`=1 while `sel`≠2.
  - At the next `out_ch`=2: `out_mux_eve`=1, `out_mux_pol_eve`=1, `out_ovf`=0.
  - At the following ch2 slot: `out_mux_eve`=0.
- **Overflow:** two events on ch1 before its slot, polarities 1 then 0.
  - ch1 slot reports eve=1, pol=0, `out_ovf`=1.
  - Next ch1 slot reports all zero.
- **Same-cycle read and event:** `in_eve[0]`=1 in the cycle `sel`=0 while `pend[0]`=1.
  - Current slot reports eve=1, ovf=0.
  - Next ch0 slot, 2 cycles later, reports eve=1.
- **Enable low:** drop `en` for 5 cycles and pulse `in_eve[3]` during them.
  - `out_valid`=0 and `out_ch` holds.
  - After re-enable the sequence resumes where it stopped, and the ch3 event appears at the next ch3 slot.
- **Mid-run reset:** `rstb`=0 for 1 cycle with events pending on all channels. The next slot sequence starts at ch0, and all reads report 0.
